// File: rtl/button_events_if.sv
// Push-button event bus: raw button level in, debounced level and
// one-cycle event pulses out.
interface button_events_if;
  logic btn_raw;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic short_pulse;
  logic long_pulse;

  // Driver of the raw button / consumer of the events
  modport master (
    output btn_raw,
    input  btn_level,
    input  press_pulse,
    input  release_pulse,
    input  short_pulse,
    input  long_pulse
  );

  // The event generator itself
  modport slave (
    input  btn_raw,
    output btn_level,
    output press_pulse,
    output release_pulse,
    output short_pulse,
    output long_pulse
  );
endinterface

// File: rtl/button_events.sv
// Push-button debouncer with press / release / short / long event pulses.
//
// state   | meaning
// --------+---------------------------------------------------
// IDLE    | debounced level low, waiting for a press
// PRESSED | debounced level high, hold timer running
// HELD    | long press already reported, waiting for release
module button_events #(
  parameter int CLK_HZ      = 50000000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000
) (
  input  logic            clk,
  input  logic            reset,
  button_events_if.slave  bus
);

  localparam int DIV = CLK_HZ / 1000;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [7:0]    DEB_LAST   = 8'(DEBOUNCE_MS - 1);
  localparam logic [15:0]   LONG_LAST  = 16'(LONG_MS - 1);

  typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;

  logic          sync_1;
  logic          btn_sync;
  logic [PW-1:0] presc_q;
  logic          ms_tick;
  logic [7:0]    deb_cnt;
  logic          btn_level;
  logic          accept;
  logic          level_rise;
  logic          level_fall;

  state_t        state_q, state_d;
  logic [15:0]   hold_q, hold_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          short_q, short_d;
  logic          long_q, long_d;

  // Two-flop synchronizer: the only place btn_raw is sampled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_1   <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      sync_1   <= bus.btn_raw;
      btn_sync <= sync_1;
    end
  end

  // Millisecond prescaler; with DIV == 1 the counter sits at 0 and ticks every cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
    end else if (presc_q == PRESC_LAST) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  assign ms_tick    = (presc_q == PRESC_LAST);
  assign accept     = ms_tick && (btn_sync != btn_level) && (deb_cnt == DEB_LAST);
  assign level_rise = accept && !btn_level;
  assign level_fall = accept && btn_level;

  // Debounce: count ms while the synchronized input disagrees, toggle when stable long enough
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_cnt   <= '0;
      btn_level <= 1'b0;
    end else if (btn_sync == btn_level) begin
      deb_cnt <= '0;
    end else if (ms_tick) begin
      if (deb_cnt == DEB_LAST) begin
        btn_level <= ~btn_level;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + 8'd1;
      end
    end
  end

  // FSM state, hold timer and registered event pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      press_q   <= press_d;
      release_q <= release_d;
      short_q   <= short_d;
      long_q    <= long_d;
    end
  end

  // Next state and pulses; a release on the threshold edge beats the long press
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (level_rise) begin
          state_d = PRESSED;
          hold_d  = '0;
          press_d = 1'b1;
        end
      end
      PRESSED: begin
        if (level_fall) begin
          state_d   = IDLE;
          release_d = 1'b1;
          short_d   = 1'b1;
        end else if (ms_tick) begin
          if (hold_q == LONG_LAST) begin
            state_d = HELD;
            long_d  = 1'b1;
          end else begin
            hold_d = hold_q + 16'd1;
          end
        end
      end
      HELD: begin
        if (level_fall) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.btn_level     = btn_level;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.short_pulse   = short_q;
  assign bus.long_pulse    = long_q;

endmodule

// File: doc/button_events.md
BUTTON_EVENTS -- requirements
Module: button_events

Interface
REQ-001 Parameter CLK_HZ, default 50000000: clock frequency in Hz; SHALL be a nonzero integer multiple of 1000.
REQ-002 Parameter DEBOUNCE_MS, default 20: stable time in ms required to accept a level change; range 1..255.
REQ-003 Parameter LONG_MS, default 1000: press duration in ms that qualifies as a long press; range 1..65535.
REQ-004 clk  input  1  single clock; all state SHALL change only on its rising edge, except on reset.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 btn_raw  input  1  asynchronous, bouncy push-button level, 1 = pressed.
REQ-007 btn_level  output  1  debounced button level, registered.
REQ-008 press_pulse  output  1  one-cycle pulse on the debounced 0->1 transition.
REQ-009 release_pulse  output  1  one-cycle pulse on the debounced 1->0 transition.
REQ-010 short_pulse  output  1  one-cycle pulse on release when the long-press threshold was not reached.
REQ-011 long_pulse  output  1  one-cycle pulse when a press reaches LONG_MS; SHALL be issued at most once per press.

Function
REQ-012 btn_raw SHALL pass through a 2-flop synchronizer; btn_sync is the second flop, and no other logic SHALL sample btn_raw.
REQ-013 Prescaler: counter 0..CLK_HZ/1000-1, wrapping to 0; ms_tick SHALL be high in cycles where the count equals CLK_HZ/1000-1 (constant 1 when CLK_HZ=1000).
REQ-014 Debounce counter (8 bit): cleared whenever btn_sync == btn_level; incremented on ms_tick while they differ.
REQ-015 When ms_tick, btn_sync != btn_level and the debounce count == DEBOUNCE_MS-1, btn_level SHALL toggle and the counter SHALL clear on the same edge.
REQ-016 A btn_sync mismatch that ends before acceptance SHALL produce no output change and SHALL clear the counter.
REQ-017 FSM states: IDLE (btn_level=0), PRESSED (hold timer running), HELD (long press already reported).
REQ-018 IDLE -> PRESSED on the edge where btn_level rises; press_pulse SHALL be high for the following cycle only, and the 16-bit hold counter SHALL clear.
REQ-019 In PRESSED, the hold counter SHALL increment on ms_tick; if ms_tick and the hold count == LONG_MS-1, the FSM SHALL move to HELD with long_pulse high for one cycle.
REQ-020 PRESSED -> IDLE on a debounced fall; release_pulse and short_pulse SHALL both be high for one cycle.
REQ-021 HELD -> IDLE on a debounced fall; release_pulse SHALL be high for one cycle and short_pulse SHALL stay low.
REQ-022 Simultaneous debounced fall and long threshold in PRESSED: the release SHALL win, giving release_pulse and short_pulse; long_pulse SHALL NOT be issued.
REQ-023 All pulse outputs SHALL be registered; at most one of short_pulse and long_pulse SHALL be high in any press cycle.
REQ-024 Latency: btn_level and press_pulse or release_pulse SHALL change exactly 2 + DEBOUNCE_MS*CLK_HZ/1000 rising edges after a clean btn_raw step that occurs just before an edge, with the prescaler phase aligned.

Reset
REQ-025 On reset, all of the following SHALL clear to 0 asynchronously: synchronizer, prescaler, debounce counter, hold counter, btn_level and all pulses; the FSM SHALL return to IDLE.
REQ-026 Reset asserted mid-press SHALL emit no release or short pulse.
REQ-027 If the button is held when reset deasserts, a normal debounced press_pulse SHALL follow (6 edges with the test parameters).

Verification (CLK_HZ=1000, DEBOUNCE_MS=4, LONG_MS=10)
REQ-028 Clean press: btn_raw 0->1 held -> btn_level=1 and press_pulse high for one cycle at edge 6; no other pulses.
REQ-029 Bounce: btn_raw pattern 1,0,1,1,0 over 5 cycles then 0 -> btn_level stays 0 and all pulses stay 0.
REQ-030 Short press: raw high for 8 cycles then low -> press at edge 6, then release_pulse and short_pulse together, long_pulse never asserted.
REQ-031 Long press: raw high for 30 cycles -> long_pulse once, 10 edges after press_pulse; on release, release_pulse only.
REQ-032 Tie case: raw release timed so the debounced fall lands on the long-threshold edge -> release_pulse=1, short_pulse=1, long_pulse=0.
REQ-033 Reset mid-HELD: assert reset -> all outputs 0 immediately; release reset with raw=1 -> press_pulse at edge 6.
